// File: rtl/dvp_rgb444_tx.sv
// OV7670-style DVP transmitter: vref/href frame timing with RGB444 pixels sent as two bytes.
// Optional internal 8-bar colour generator is built when DVP_TEST_PATTERN_EN is defined.
module dvp_rgb444_tx #(
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter int          H_BLANK     = 144,
    parameter int          VSYNC_LINES = 3,
    parameter int          V_BACK      = 17,
    parameter int          V_FRONT     = 10,
    parameter logic [11:0] FILL_RGB    = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [11:0] pix_data,
    input  logic        pix_valid,
`ifdef DVP_TEST_PATTERN_EN
    input  logic        pattern_en,
`endif
    output logic        pix_ready,
    output logic        vref,
    output logic        href,
    output logic [7:0]  d,
    output logic        frame_start,
    output logic        line_end,
    output logic        underrun,
    output logic        busy
);

    localparam int LINE  = 2 * H_ACTIVE + H_BLANK;
    localparam int HC_W  = $clog2(LINE);
    localparam int V_M1  = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int V_M2  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int V_MAX = (V_M1 > V_M2) ? V_M1 : V_M2;
    localparam int LC_W  = (V_MAX > 1) ? $clog2(V_MAX) : 1;

    localparam logic [HC_W-1:0] HC_LAST     = HC_W'(LINE - 1);
    localparam logic [HC_W-1:0] HC_ACT      = HC_W'(2 * H_ACTIVE);
    localparam logic [HC_W-1:0] HC_ACT_LAST = HC_W'(2 * H_ACTIVE - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_n_s;
    logic [HC_W-1:0]   hcnt_r;
    logic [HC_W-1:0]   hcnt_n_s;
    logic [LC_W-1:0]   lcnt_r;
    logic [LC_W-1:0]   lcnt_n_s;
    logic [11:0]       pix_r;
    logic [11:0]       pix_sel_s;
    logic              act_slot_s;
    logic              next_line_act_s;
    logic              ready_n_s;
    logic              fs_n_s;
    logic              pat_mode_s;

    function automatic logic [LC_W-1:0] last_line(input state_t st);
        case (st)
            ST_VSYNC:  return LC_W'(VSYNC_LINES - 1);
            ST_VBACK:  return LC_W'(V_BACK - 1);
            ST_ACTIVE: return LC_W'(V_ACTIVE - 1);
            ST_VFRONT: return LC_W'(V_FRONT - 1);
            default:   return {LC_W{1'b0}};
        endcase
    endfunction

`ifdef DVP_TEST_PATTERN_EN
    logic pattern_r;

    function automatic logic [11:0] bar_colour(input logic [HC_W-1:0] hc);
        int         px;
        int         bar;
        logic [2:0] b;
        px  = int'(hc >> 1);
        bar = (px * 8) / H_ACTIVE;
        b   = bar[2:0];
        return {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
    endfunction

    assign pat_mode_s = pattern_r;

    // Latch the pattern selection once per frame so a frame is never mixed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pattern_r <= 1'b0;
        end else if (fs_n_s) begin
            pattern_r <= pattern_en;
        end else begin
            pattern_r <= pattern_r;
        end
    end
`else
    assign pat_mode_s = 1'b0;
`endif

    // Next raster position; the output registers are loaded from it so they line up with the counters.
    always_comb begin
        state_n_s = state_r;
        hcnt_n_s  = hcnt_r;
        lcnt_n_s  = lcnt_r;
        if (state_r == ST_IDLE) begin
            hcnt_n_s  = {HC_W{1'b0}};
            lcnt_n_s  = {LC_W{1'b0}};
            state_n_s = en ? ST_VSYNC : ST_IDLE;
        end else if (hcnt_r == HC_LAST) begin
            hcnt_n_s = {HC_W{1'b0}};
            if (lcnt_r == last_line(state_r)) begin
                lcnt_n_s = {LC_W{1'b0}};
                case (state_r)
                    ST_VSYNC:  state_n_s = ST_VBACK;
                    ST_VBACK:  state_n_s = ST_ACTIVE;
                    ST_ACTIVE: state_n_s = ST_VFRONT;
                    ST_VFRONT: state_n_s = en ? ST_VSYNC : ST_IDLE;
                    default:   state_n_s = ST_IDLE;
                endcase
            end else begin
                lcnt_n_s = lcnt_r + LC_W'(1);
            end
        end else begin
            hcnt_n_s = hcnt_r + HC_W'(1);
        end
    end

    // Slot decode for the upcoming cycle, including the look-ahead for the first pixel of a line.
    always_comb begin
        act_slot_s      = (state_n_s == ST_ACTIVE) && (hcnt_n_s < HC_ACT);
        fs_n_s          = (state_n_s == ST_VSYNC) && (state_r != ST_VSYNC);
        next_line_act_s = (hcnt_n_s == HC_LAST) &&
                          (((state_n_s == ST_VBACK) && (lcnt_n_s == last_line(ST_VBACK))) ||
                           ((state_n_s == ST_ACTIVE) && (lcnt_n_s != last_line(ST_ACTIVE))));
        ready_n_s       = !pat_mode_s &&
                          ((act_slot_s && hcnt_n_s[0] && (hcnt_n_s != HC_ACT_LAST)) || next_line_act_s);
    end

    // Pixel captured at a high-byte slot: generator, stream, or the fill colour on underrun.
    always_comb begin
        pix_sel_s = FILL_RGB;
`ifdef DVP_TEST_PATTERN_EN
        if (pat_mode_s) begin
            pix_sel_s = bar_colour(hcnt_n_s);
        end else if (pix_valid) begin
            pix_sel_s = pix_data;
        end else begin
            pix_sel_s = FILL_RGB;
        end
`else
        if (pix_valid) begin
            pix_sel_s = pix_data;
        end else begin
            pix_sel_s = FILL_RGB;
        end
`endif
    end

    // Raster state and all registered bus outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            hcnt_r      <= {HC_W{1'b0}};
            lcnt_r      <= {LC_W{1'b0}};
            pix_r       <= 12'h000;
            vref        <= 1'b0;
            href        <= 1'b0;
            d           <= 8'h00;
            pix_ready   <= 1'b0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            underrun    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            hcnt_r      <= hcnt_n_s;
            lcnt_r      <= lcnt_n_s;
            busy        <= (state_n_s != ST_IDLE);
            vref        <= (state_n_s == ST_VSYNC);
            frame_start <= fs_n_s;
            href        <= act_slot_s;
            line_end    <= act_slot_s && (hcnt_n_s == HC_ACT_LAST);
            pix_ready   <= ready_n_s;
            if (act_slot_s && !hcnt_n_s[0]) begin
                pix_r <= pix_sel_s;
                d     <= pix_sel_s[11:4];
            end else if (act_slot_s) begin
                pix_r <= pix_r;
                d     <= {pix_r[3:0], 4'h0};
            end else begin
                pix_r <= pix_r;
                d     <= 8'h00;
            end
            if (pix_ready && !pix_valid) begin
                underrun <= 1'b1;
            end else begin
                underrun <= underrun;
            end
        end
    end

endmodule
